// File: rtl/pio_pkg.sv
// Shared definitions for the PIO loader: command codes, sequencer states and
// the bit layout of a configuration table entry.
package pio_pkg;

    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PUSH  = 4'd4;

    localparam int CONF_MIDX = 36;
    localparam int CONF_ACT  = 32;
    localparam int CONF_DATA = 0;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_PROG  = 3'd1,
        LD_CONF  = 3'd2,
        LD_DRAIN = 3'd3,
        LD_RUN   = 3'd4
    } ld_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc16 = value;
        end else begin
            sat_inc16 = value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/pio_loader.sv
// Sequencer in front of the pio command port: streams program words, then the
// configuration table, then pushes a valid/ready byte stream into one TX FIFO.
module pio_loader
    import pio_pkg::*;
#(
    parameter int PROG_LEN   = 32,
    parameter int CONF_LEN   = 6,
    parameter int STREAM_SM  = 0,
    parameter int PUSH_GAP   = 2,
    parameter bit AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    output logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    output logic [4:0]  conf_addr,
    input  logic [37:0] conf_data,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  tx_full,
    output logic [3:0]  action,
    output logic [4:0]  index,
    output logic [31:0] din,
    output logic [1:0]  mindex,
    output logic        busy,
    output logic        loaded,
    output logic [15:0] stall_cnt
);

    localparam logic [4:0] PROG_LAST  = 5'(PROG_LEN - 1);
    localparam logic [4:0] CONF_LAST  = 5'(CONF_LEN - 1);
    localparam logic [1:0] SM_IDX     = 2'(STREAM_SM);
    localparam logic [7:0] GAP_LOAD   = 8'(PUSH_GAP);
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    ld_state_t   state_r, state_s;
    logic [4:0]  prog_addr_r, prog_addr_s;
    logic [4:0]  conf_addr_r, conf_addr_s;
    logic        prog_vld_r, prog_vld_s;
    logic        conf_vld_r, conf_vld_s;
    logic [4:0]  prog_idx_r;
    logic [1:0]  drain_r, drain_s;
    logic [7:0]  gap_r, gap_s;
    logic        auto_r;
    logic        go_s;
    logic        accept_s;
    logic        stream_full_s;
    logic        tx_full_unused_s;

    logic [3:0]  action_r, action_s;
    logic [4:0]  index_r, index_s;
    logic [31:0] din_r, din_s;
    logic [1:0]  mindex_r, mindex_s;
    logic        busy_r, busy_s;
    logic        loaded_r, loaded_s;
    logic [15:0] stall_r, stall_s;

    // Only the streamed SM's full flag matters; the others are reduced away.
    assign stream_full_s    = tx_full[SM_IDX];
    assign tx_full_unused_s = ^tx_full;

    // A load is honoured from IDLE (start or auto-start) and from RUN (start only).
    assign go_s = ((state_r == LD_IDLE) && (start || auto_r)) ||
                  ((state_r == LD_RUN) && start);

    // start masks s_ready in the same cycle so no byte is taken just before a reload.
    assign accept_s = (state_r == LD_RUN) && s_valid && !stream_full_s &&
                      (gap_r == 8'd0) && !start;

    // Next-state logic and memory address sequencing.
    always_comb begin
        state_s     = state_r;
        prog_addr_s = prog_addr_r;
        conf_addr_s = conf_addr_r;
        prog_vld_s  = 1'b0;
        conf_vld_s  = 1'b0;
        drain_s     = drain_r;
        case (state_r)
            LD_IDLE: begin
                if (go_s) begin
                    state_s     = LD_PROG;
                    prog_addr_s = 5'd0;
                end else begin
                    state_s = LD_IDLE;
                end
            end
            LD_PROG: begin
                prog_vld_s = 1'b1;
                if (prog_addr_r == PROG_LAST) begin
                    prog_addr_s = 5'd0;
                    conf_addr_s = 5'd0;
                    state_s     = LD_CONF;
                end else begin
                    prog_addr_s = prog_addr_r + 5'd1;
                end
            end
            LD_CONF: begin
                conf_vld_s = 1'b1;
                if (conf_addr_r == CONF_LAST) begin
                    conf_addr_s = 5'd0;
                    drain_s     = 2'd0;
                    state_s     = LD_DRAIN;
                end else begin
                    conf_addr_s = conf_addr_r + 5'd1;
                end
            end
            LD_DRAIN: begin
                // Covers the read latency of the last entry plus one idle command slot.
                if (drain_r == DRAIN_LAST) begin
                    state_s = LD_RUN;
                end else begin
                    drain_s = drain_r + 2'd1;
                end
            end
            LD_RUN: begin
                if (go_s) begin
                    state_s     = LD_PROG;
                    prog_addr_s = 5'd0;
                end else begin
                    state_s = LD_RUN;
                end
            end
            default: begin
                state_s     = LD_IDLE;
                prog_addr_s = 5'd0;
                conf_addr_s = 5'd0;
                drain_s     = 2'd0;
            end
        endcase
    end

    // Command selection: read data is tagged valid one cycle after its address.
    always_comb begin
        action_s = ACT_NONE;
        index_s  = 5'd0;
        din_s    = 32'd0;
        mindex_s = 2'd0;
        if (prog_vld_r) begin
            action_s = ACT_INSTR;
            index_s  = prog_idx_r;
            din_s    = {16'h0000, prog_data};
        end else if (conf_vld_r) begin
            action_s = conf_data[CONF_ACT +: 4];
            din_s    = conf_data[CONF_DATA +: 32];
            mindex_s = conf_data[CONF_MIDX +: 2];
        end else if (accept_s) begin
            action_s = ACT_PUSH;
            din_s    = {24'h000000, s_data};
            mindex_s = SM_IDX;
        end else begin
            action_s = ACT_NONE;
        end
    end

    // Status flags follow the next state; inter-push gap and stall counter.
    always_comb begin
        if ((state_s == LD_PROG) || (state_s == LD_CONF) || (state_s == LD_DRAIN)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
        loaded_s = (state_s == LD_RUN);
        if (accept_s) begin
            gap_s = GAP_LOAD;
        end else if (gap_r != 8'd0) begin
            gap_s = gap_r - 8'd1;
        end else begin
            gap_s = gap_r;
        end
        if (go_s) begin
            stall_s = 16'd0;
        end else if ((state_r == LD_RUN) && s_valid && stream_full_s) begin
            stall_s = sat_inc16(stall_r);
        end else begin
            stall_s = stall_r;
        end
    end

    // Sequencer state, address counters and read-valid tags.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r     <= LD_IDLE;
            prog_addr_r <= 5'd0;
            conf_addr_r <= 5'd0;
            prog_vld_r  <= 1'b0;
            conf_vld_r  <= 1'b0;
            prog_idx_r  <= 5'd0;
            drain_r     <= 2'd0;
            gap_r       <= 8'd0;
            auto_r      <= AUTO_START;
        end else begin
            state_r     <= state_s;
            prog_addr_r <= prog_addr_s;
            conf_addr_r <= conf_addr_s;
            prog_vld_r  <= prog_vld_s;
            conf_vld_r  <= conf_vld_s;
            prog_idx_r  <= prog_addr_r;
            drain_r     <= drain_s;
            gap_r       <= gap_s;
            auto_r      <= 1'b0;
        end
    end

    // Registered command and status outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            action_r <= ACT_NONE;
            index_r  <= 5'd0;
            din_r    <= 32'd0;
            mindex_r <= 2'd0;
            busy_r   <= 1'b0;
            loaded_r <= 1'b0;
            stall_r  <= 16'd0;
        end else begin
            action_r <= action_s;
            index_r  <= index_s;
            din_r    <= din_s;
            mindex_r <= mindex_s;
            busy_r   <= busy_s;
            loaded_r <= loaded_s;
            stall_r  <= stall_s;
        end
    end

    assign prog_addr = prog_addr_r;
    assign conf_addr = conf_addr_r;
    assign s_ready   = accept_s;
    assign action    = action_r;
    assign index     = index_r;
    assign din       = din_r;
    assign mindex    = mindex_r;
    assign busy      = busy_r;
    assign loaded    = loaded_r;
    assign stall_cnt = stall_r;

endmodule

// File: tb/tb_pio_loader.sv
// Bench for pio_loader: a load/run timeline model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pio_loader;

    localparam int P   = 32;
    localparam int C   = 6;
    localparam int SM  = 0;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  prog_addr, conf_addr, index;
    logic [15:0] prog_data = 16'h0000;
    logic [37:0] conf_data = 38'd0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready, busy, loaded;
    logic [3:0]  tx_full = 4'h0;
    logic [3:0]  action;
    logic [31:0] din;
    logic [1:0]  mindex;
    logic [15:0] stall_cnt;

    logic [37:0] conf_mem [0:31];
    logic [7:0]  src_q[$];
    logic        valid_en = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pio_loader #(
        .PROG_LEN(P), .CONF_LEN(C), .STREAM_SM(SM), .PUSH_GAP(GAP), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .n_reset(n_reset), .start(start),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .conf_addr(conf_addr), .conf_data(conf_data),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .tx_full(tx_full),
        .action(action), .index(index), .din(din), .mindex(mindex),
        .busy(busy), .loaded(loaded), .stall_cnt(stall_cnt)
    );

    // Synchronous-read instruction and configuration memories.
    always @(posedge clk) begin
        prog_data <= 16'h1000 + {11'd0, prog_addr};
        conf_data <= conf_mem[conf_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    // Timeline model: mode 0 idle, 1 loading (k = cycles since load began), 2 run.
    int mode = 0, k = 0, cyc = 0, last_acc = -100, stall_m = 0;
    bit auto_m = 1'b1, acc = 1'b0, push_pend = 1'b0;
    logic [7:0] acc_byte = 8'h00, push_byte = 8'h00;

    initial begin : model
        logic [3:0]  e_act;
        logic [4:0]  e_idx, e_pa, e_ca;
        logic [31:0] e_din;
        logic [1:0]  e_mi;
        logic        e_rdy, e_busy, e_loaded;
        int          j;
        forever begin
            @(posedge clk);
            if (!n_reset) begin
                mode = 0; k = 0; auto_m = 1'b1; stall_m = 0;
                push_pend = 1'b0; last_acc = -100;
            end else begin
                push_pend = acc;
                push_byte = acc_byte;
                if (acc) begin
                    last_acc = cyc;
                    void'(src_q.pop_front());
                end
                if (((mode == 0) && (start || auto_m)) || ((mode == 2) && start)) begin
                    stall_m = 0;
                end else if ((mode == 2) && s_valid && tx_full[SM] && (stall_m < 65535)) begin
                    stall_m++;
                end
                if (mode == 0) begin
                    if (start || auto_m) begin mode = 1; k = 0; end
                end else if (mode == 1) begin
                    k++;
                    if (k == P + C + 3) mode = 2;
                end else begin
                    if (start) begin mode = 1; k = 0; end
                end
                auto_m = 1'b0;
            end
            acc = 1'b0;
            cyc++;
            #2;
            s_valid = valid_en && (src_q.size() > 0);
            s_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
            @(negedge clk);
            e_act = 4'd0; e_idx = 5'd0; e_din = 32'd0; e_mi = 2'd0;
            e_pa = 5'd0; e_ca = 5'd0; e_rdy = 1'b0; e_busy = 1'b0; e_loaded = 1'b0;
            if (n_reset) begin
                e_busy   = (mode == 1);
                e_loaded = (mode == 2);
                if (push_pend) begin
                    e_act = 4'd4; e_din = {24'd0, push_byte}; e_mi = 2'(SM);
                end else if ((mode == 1) && (k >= 2) && (k < 2 + P)) begin
                    e_act = 4'd1; e_idx = 5'(k - 2); e_din = 32'h1000 + 32'(k - 2);
                end else if ((mode == 1) && (k >= 2 + P) && (k < 2 + P + C)) begin
                    j = k - 2 - P;
                    e_act = conf_mem[j][35:32]; e_din = conf_mem[j][31:0]; e_mi = conf_mem[j][37:36];
                end
                if ((mode == 1) && (k < P)) e_pa = 5'(k);
                if ((mode == 1) && (k >= P) && (k < P + C)) e_ca = 5'(k - P);
                e_rdy = (mode == 2) && s_valid && !tx_full[SM] && !start && (cyc - last_acc > GAP);
            end
            chk("action", action, e_act);
            chk("index", index, e_idx);
            chk("din", din, e_din);
            chk("mindex", mindex, e_mi);
            chk("busy", busy, e_busy);
            chk("loaded", loaded, e_loaded);
            chk("s_ready", s_ready, e_rdy);
            chk("stall_cnt", stall_cnt, n_reset ? 64'(stall_m) : 64'd0);
            chk("prog_addr", prog_addr, e_pa);
            chk("conf_addr", conf_addr, e_ca);
            acc      = e_rdy && n_reset;
            acc_byte = s_data;
        end
    end

    // Event recorder for the literal checks.
    int mcyc = 0, n_instr = 0, first_idx = -1, first_wr_cyc = -1, last_idx = -1;
    int dbf_cyc = -1, loaded_cyc = -1;
    logic [31:0] dbf_din = 32'd0;
    logic [1:0]  dbf_mi = 2'd0;
    logic        loaded_prev = 1'b0;
    logic [7:0]  pushed_q[$];
    int          push_cyc_q[$];

    initial begin : monitor
        forever begin
            @(negedge clk);
            mcyc++;
            if (n_reset) begin
                if (action == 4'd1) begin
                    n_instr++;
                    last_idx = int'(index);
                    if (first_idx < 0) begin
                        first_idx = int'(index);
                        first_wr_cyc = mcyc;
                    end
                end
                if (action == 4'd3) begin
                    dbf_cyc = mcyc; dbf_din = din; dbf_mi = mindex;
                end
                if (loaded && !loaded_prev) loaded_cyc = mcyc;
                if (action == 4'd4) begin
                    pushed_q.push_back(din[7:0]);
                    push_cyc_q.push_back(mcyc);
                end
            end
            loaded_prev = loaded;
        end
    end

    task automatic wait_loaded(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (loaded) begin ok = 1'b1; break; end
        end
        if (!ok) chk(name, 64'd0, 64'd1);
        @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (src_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk(name, 64'd0, 64'd1);
        repeat (3) @(posedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit found;
        for (int i = 0; i < 32; i++) conf_mem[i] = 38'd0;
        conf_mem[0] = {2'd0, 4'd2, 32'h11110000};
        conf_mem[1] = {2'd3, 4'd5, 32'h22220001};
        conf_mem[2] = {2'd1, 4'd3, 32'hDEADBEEF};
        conf_mem[3] = {2'd2, 4'd6, 32'h33330003};
        conf_mem[4] = {2'd0, 4'd0, 32'hA5A5A5A5};
        conf_mem[5] = {2'd1, 4'd7, 32'h55550005};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_action", action, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall_cnt, 16'd0);
        chk("rst_ready", s_ready, 1'b0);
        @(posedge clk); #1 n_reset = 1'b1;

        // Auto-start load, with a start pulse while in CONF that must be ignored
        repeat (35) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_loaded("load1_timeout");
        chk("load1_instr_count", 64'(n_instr), 64'd32);
        chk("load1_first_index", 64'(first_idx), 64'd0);
        chk("load1_span", 64'(loaded_cyc - first_wr_cyc), 64'd39);
        chk("conf2_din", dbf_din, 32'hDEADBEEF);
        chk("conf2_mindex", dbf_mi, 2'd1);
        chk("conf2_pos", 64'(dbf_cyc - first_wr_cyc), 64'd34);

        // Free-running stream, pushes every PUSH_GAP+1 cycles
        #1;
        for (int i = 0; i < 10; i++) src_q.push_back(8'h30 + 8'(i));
        valid_en = 1'b1;
        wait_drain("t3_timeout");
        chk("t3_push_count", 64'(pushed_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) chk("t3_byte", pushed_q[i], 64'(8'h30 + 8'(i)));
        for (int i = 1; i < 10; i++) chk("t3_spacing", 64'(push_cyc_q[i] - push_cyc_q[i-1]), 64'd3);

        // Back-pressure: ten stalled cycles, then release
        #1 tx_full = 4'b0001;
        for (int i = 0; i < 5; i++) src_q.push_back(8'h40 + 8'(i));
        repeat (10) @(posedge clk);
        #1 chk("t4_stall_cnt", stall_cnt, 16'd10);
        chk("t4_push_held", 64'(pushed_q.size()), 64'd10);
        tx_full = 4'b0110;
        wait_drain("t4_timeout");
        chk("t4_push_count", 64'(pushed_q.size()), 64'd15);
        for (int i = 0; i < 5; i++) chk("t4_byte", pushed_q[10 + i], 64'(8'h40 + 8'(i)));

        // start while streaming in RUN: reload, then the rest of the stream
        #1;
        for (int i = 0; i < 8; i++) src_q.push_back(8'h50 + 8'(i));
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_instr = 0;
        @(negedge clk);
        chk("t5_loaded_drop", loaded, 1'b0);
        chk("t5_busy_rise", busy, 1'b1);
        chk("t5_stall_clear", stall_cnt, 16'd0);
        wait_loaded("t5_timeout");
        chk("t5_instr_count", 64'(n_instr), 64'd32);
        wait_drain("t5_drain_timeout");
        chk("t5_push_count", 64'(pushed_q.size()), 64'd23);
        for (int i = 0; i < 8; i++) chk("t5_byte", pushed_q[15 + i], 64'(8'h50 + 8'(i)));

        // Reset in the middle of the program load
        valid_en = 1'b0;
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        last_idx = -1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (last_idx == 12) begin found = 1'b1; break; end
        end
        if (!found) chk("t6_index12_timeout", 64'd0, 64'd1);
        @(posedge clk); #1 n_reset = 1'b0;
        #1;
        chk("t6_action", action, 4'd0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_din", din, 32'd0);
        chk("t6_prog_addr", prog_addr, 5'd0);
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        first_idx = -1;
        n_instr = 0;
        wait_loaded("t6_timeout");
        chk("t6_first_index", 64'(first_idx), 64'd0);
        chk("t6_instr_count", 64'(n_instr), 64'd32);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
